// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the core front end.
//   XLEN       - architectural register / address width
//   NOP_INSTR  - canonical NOP (addi x0, x0, 0) shown to decode when idle
//   fetch_rec_t- one fetched instruction paired with the PC it came from
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Packed so it can travel through a plain WIDTH-bit FIFO; pc is the
    // upper half, instr the lower half.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with head (first-word fall-through) read port.
//   clk        - clock, all state changes on posedge
//   reset      - synchronous active-high reset, empties the FIFO
//   clear      - synchronous flush, same effect as reset, wins over push/pop
//   push       - write push_data; accepted when not full, or when full and
//                a pop happens in the same cycle
//   push_data  - data to write
//   pop        - discard the head entry; ignored when empty
//   head_data  - oldest entry (undefined content when empty)
//   count      - number of stored entries, 0..DEPTH
//   full/empty - occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// Instruction-fetch front end feeding decode. Owns the fetch PC, issues
// in-order requests to instruction memory, tracks the PCs of outstanding
// requests, buffers returned instructions and presents one per cycle to ID.
//   clk, reset       - clock; synchronous active-high reset
//   stall            - hazard unit: hold ID outputs, do not pop
//   redirect         - taken branch/jump from EX, flushes wrong-path work
//   redirect_pc      - new fetch target on redirect
//   imem_req_valid   - request offered (address = current fetch PC)
//   imem_req_addr    - request address
//   imem_req_ready   - memory accepts the request this cycle
//   imem_resp_valid  - in-order response, at least one cycle after accept
//   imem_resp_data   - instruction word of the response
//   valid_ID         - instr_ID / PC_ID hold a real instruction
//   instr_ID, PC_ID  - instruction and its PC (NOP / 0 when not valid)
// Flow control is credit based: requests in flight plus buffered
// instructions never exceed DEPTH, so the buffer cannot overflow.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            valid_ID,
    output logic [XLEN-1:0] instr_ID,
    output logic [XLEN-1:0] PC_ID
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;

    logic [XLEN-1:0] pend_head;
    logic [CW-1:0]   pend_count;
    logic            pend_full;
    logic            pend_empty;

    fetch_rec_t      buf_head;
    fetch_rec_t      buf_push_rec;
    logic [CW-1:0]   buf_count;
    logic            buf_full;
    logic            buf_empty;

    logic [CW:0]     credit_used;
    logic            accept;
    logic            resp;
    logic            resp_keep;
    logic            resp_drop;
    logic            pend_pop;
    logic            buf_push;
    logic            pop_id;
    logic            pend_count_unused;

    // Every outstanding request and every buffered instruction holds one
    // credit; a new request is only offered while a credit is free.
    assign credit_used = {1'b0, inflight} + {1'b0, buf_count};

    assign imem_req_valid = !reset && !redirect && (credit_used < DEPTH_W)
                            && !pend_full;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp      = imem_resp_valid && (inflight != '0);
    assign resp_drop = resp && (drop != '0);
    assign resp_keep = resp && (drop == '0);

    // Dropped responses belong to requests whose PCs were already flushed
    // from the pending queue, so only kept responses consume a pending PC.
    assign pend_pop  = resp_keep && !pend_empty;
    assign buf_push  = resp_keep && !redirect && (!buf_full || pop_id);
    assign pop_id    = !buf_empty && !stall && !redirect;

    assign buf_push_rec = '{pc: pend_head, instr: imem_resp_data};

    // Pending occupancy always equals inflight - drop; kept only for debug.
    assign pend_count_unused = ^pend_count;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (pend_pop),
        .head_data (pend_head),
        .count     (pend_count),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_rec_t)),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (buf_push),
        .push_data (buf_push_rec),
        .pop       (pop_id),
        .head_data (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Fetch PC, outstanding-request count and wrong-path drop count.
    // On redirect every request still outstanding (minus a response that
    // lands in the same cycle, which is discarded) becomes wrong-path.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= inflight - CW'(resp);
            drop     <= inflight - CW'(resp);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CW'(accept) - CW'(resp);
            if (resp_drop) begin
                drop <= drop - 1'b1;
            end
        end
    end

    assign valid_ID = !buf_empty;
    assign instr_ID = buf_empty ? NOP_INSTR : buf_head.instr;
    assign PC_ID    = buf_empty ? '0 : buf_head.pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
// Directed bench for if_fetch_stage (DEPTH = 4). A small in-order memory
// model answers requests with data = addr ^ 32'hA5A5_0000 after a chosen
// delay. Expected PCs come from a scoreboard that follows decode pops,
// redirects and resets.
module tb_if_fetch_stage;

    localparam int          TB_DEPTH  = 4;
    localparam logic [31:0] TB_RST_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_MASK = 32'hA5A5_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        valid_ID;
    logic [31:0] instr_ID;
    logic [31:0] PC_ID;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int          cyc;
    int          resp_delay;
    bit          random_delay;
    logic        seen_req_valid;
    logic [31:0] seen_req_addr;
    logic [31:0] exp_pc;
    logic [31:0] f_pc;
    logic [31:0] start_pc;
    int          vector_count;
    int          miss_count;

    if_fetch_stage #(
        .RESET_PC (TB_RST_PC),
        .DEPTH    (TB_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .valid_ID        (valid_ID),
        .instr_ID        (instr_ID),
        .PC_ID           (PC_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        assert (observed === expected) else begin
            miss_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs at negedge, let the memory model answer,
    // record any accepted request, then advance past the posedge and update
    // the expected-PC scoreboard.
    task automatic applyStimulus(input logic rst, input logic stl, input logic rdr,
                                 input logic [31:0] rpc, input logic rdy);
        logic     pop_will;
        int       d;
        mem_req_t ent;
        @(negedge clk);
        reset          = rst;
        stall          = stl;
        redirect       = rdr;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ent             = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = ent.addr ^ DATA_MASK;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        seen_req_valid = imem_req_valid;
        seen_req_addr  = imem_req_addr;
        pop_will       = valid_ID && !stl && !rdr;
        if (imem_req_valid && imem_req_ready) begin
            d = random_delay ? int'($urandom_range(3, 1)) : resp_delay;
            mem_q.push_back('{addr: imem_req_addr, due: cyc + d});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mem_q.delete();
            exp_pc = TB_RST_PC;
        end else if (rdr) begin
            exp_pc = rpc;
        end else if (pop_will) begin
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic checkStream(input string tag);
        if (valid_ID === 1'b1) begin
            checkOutput({tag, "_pc"}, PC_ID, exp_pc);
            checkOutput({tag, "_instr"}, instr_ID, exp_pc ^ DATA_MASK);
        end else begin
            checkOutput({tag, "_nop"}, instr_ID, NOP);
            checkOutput({tag, "_pc0"}, PC_ID, 32'h0);
        end
        checkOutput({tag, "_credit"}, 32'(mem_q.size() <= TB_DEPTH), 32'd1);
    endtask

    initial begin
        vector_count    = 0;
        miss_count      = 0;
        cyc             = 0;
        resp_delay      = 1;
        random_delay    = 1'b0;
        exp_pc          = TB_RST_PC;
        reset           = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Reset state
        applyStimulus(1, 0, 0, 32'h0, 1);
        applyStimulus(1, 0, 0, 32'h0, 1);
        checkOutput("rst_req_valid", 32'(seen_req_valid), 32'd0);
        checkOutput("rst_valid", 32'(valid_ID), 32'd0);
        checkOutput("rst_instr", instr_ID, NOP);
        checkOutput("rst_pc", PC_ID, 32'h0);

        // Fill and steady stream: first instruction two cycles after accept
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("fill_req_valid", 32'(seen_req_valid), 32'd1);
        checkOutput("fill_req_addr", seen_req_addr, TB_RST_PC);
        checkOutput("fill_valid0", 32'(valid_ID), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 1);
            checkOutput("stream_valid", 32'(valid_ID), 32'd1);
            checkOutput("stream_pc", PC_ID, 32'(4 * (i - 1)));
            checkStream("stream");
        end

        // Stall 5 cycles: outputs frozen at 0x20, fetch stops once full
        for (int s = 0; s < 5; s++) begin
            applyStimulus(0, 1, 0, 32'h0, 1);
            checkOutput("stall_pc", PC_ID, 32'h20);
            checkOutput("stall_instr", instr_ID, 32'h20 ^ DATA_MASK);
            checkOutput("stall_req_valid", 32'(seen_req_valid), (s < 2) ? 32'd1 : 32'd0);
        end
        for (int r = 1; r <= 12; r++) begin
            applyStimulus(0, 0, 0, 32'h0, 1);
            checkOutput("release_valid", 32'(valid_ID), 32'd1);
            checkOutput("release_pc", PC_ID, 32'(32 + 4 * r));
            checkStream("release");
        end

        // Drain, then redirect with two requests in flight
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 32'h0, 0);
            checkStream("drain1");
        end
        checkOutput("drain1_valid", 32'(valid_ID), 32'd0);
        resp_delay = 3;
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("redir_req_a", seen_req_addr, 32'h5C);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("redir_req_b", seen_req_addr, 32'h60);
        applyStimulus(0, 0, 1, 32'h100, 1);
        checkOutput("redir_no_req", 32'(seen_req_valid), 32'd0);
        checkOutput("redir_valid0", 32'(valid_ID), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("redir_tgt_req", seen_req_addr, 32'h100);
        checkOutput("redir_tgt_reqv", 32'(seen_req_valid), 32'd1);
        checkOutput("redir_drop1", 32'(valid_ID), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("redir_drop2", 32'(valid_ID), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("redir_wait", 32'(valid_ID), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("redir_first_v", 32'(valid_ID), 32'd1);
        checkOutput("redir_first_pc", PC_ID, 32'h100);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 32'h0, 1);
            checkStream("redir_tail");
        end

        // Redirect + stall + response in the same cycle, buffer non-empty
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 0, 0, 32'h0, 0);
            checkStream("drain2");
        end
        resp_delay = 2;
        applyStimulus(0, 0, 0, 32'h0, 1);
        f_pc = seen_req_addr;
        applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("rs_pre_valid", 32'(valid_ID), 32'd1);
        checkOutput("rs_pre_pc", PC_ID, f_pc);
        applyStimulus(0, 1, 1, 32'h200, 1);
        checkOutput("rs_flush_valid", 32'(valid_ID), 32'd0);
        checkOutput("rs_flush_instr", instr_ID, NOP);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("rs_tgt_req", seen_req_addr, 32'h200);
        checkOutput("rs_drop_valid", 32'(valid_ID), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("rs_wait_valid", 32'(valid_ID), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("rs_first_v", 32'(valid_ID), 32'd1);
        checkOutput("rs_first_pc", PC_ID, 32'h200);

        // Random ready, random 1-3 cycle response delay, occasional stall
        random_delay = 1'b1;
        start_pc     = exp_pc;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(0, 1'($urandom_range(3, 0) == 0), 0, 32'h0,
                          1'($urandom_range(1, 0)));
            checkStream("rand");
        end
        checkOutput("rand_progress", 32'(exp_pc != start_pc), 32'd1);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 0, 0, 32'h0, 0);
            checkStream("drain3");
        end
        random_delay = 1'b0;
        resp_delay   = 1;

        // Address wrap at the top of the address space
        applyStimulus(0, 0, 1, 32'hFFFF_FFF8, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_req0", seen_req_addr, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_req1", seen_req_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_pc0", PC_ID, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_req2", seen_req_addr, 32'h0000_0000);
        checkOutput("wrap_pc1", PC_ID, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_pc2", PC_ID, 32'h0000_0000);
        checkStream("wrap");
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_pc3", PC_ID, 32'h0000_0004);

        // Reset mid-stream
        applyStimulus(1, 0, 0, 32'h0, 1);
        checkOutput("mrst_req_valid", 32'(seen_req_valid), 32'd0);
        checkOutput("mrst_valid", 32'(valid_ID), 32'd0);
        checkOutput("mrst_instr", instr_ID, NOP);
        checkOutput("mrst_pc", PC_ID, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("mrst_req_v", 32'(seen_req_valid), 32'd1);
        checkOutput("mrst_req_addr", seen_req_addr, TB_RST_PC);
        checkOutput("mrst_valid1", 32'(valid_ID), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("mrst_first_v", 32'(valid_ID), 32'd1);
        checkOutput("mrst_first_pc", PC_ID, TB_RST_PC);
        checkStream("mrst");

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
